alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Pipeline register between decode and the combinational `ALU`. It captures decoded operands and selects operand sources. It applies writeback bypass and encodes the 4-bit ALU opcode, then presents `op_1_out`/`op_2_out`/`opcode_out` directly to the ALU inputs. A 2-entry skid buffer with valid/ready handshakes on both sides keeps throughput at one instruction per cycle under downstream back-pressure.

## Interface
- No parameters; datapath fixed at 32 bits, register index at 5 bits.
- `clk_in`  in  1  clock; all state updates on rising edge.
- `rst_n_in`  in  1  reset, synchronous, active-low.
- `valid_in`  in  1  upstream has an instruction.
- `ready_out`  out  1  stage can accept; transfer when `valid_in && ready_out`.
- `rs1_data_in`, `rs2_data_in`, `imm_in`, `pc_in`  in  32 each  register-file reads, sign-extended immediate, instruction PC.
- `rs1_addr_in`, `rs2_addr_in`, `rd_addr_in`  in  5 each  source and destination register indices.
- `funct3_in`  in  3  instruction funct3.
- `funct7_5_in`  in  1  funct7[5] for R-type; imm[10] for I-type shifts.
- `imm_sel_in`  in  1  1: operand 2 = `imm_in`; 0: operand 2 = rs2.
- `op1_sel_in`  in  2  operand 1 source: 00 rs1, 01 pc, 10 zero, 11 zero.
- `wb_en_in`  in  1  writeback port write enable.
- `wb_addr_in`  in  5  writeback port register index.
- `wb_data_in`  in  32  writeback port data.
- `flush_in`  in  1  discard all held and incoming instructions.
- `ready_in`  in  1  ALU/EX consumer ready.
- `valid_out`  out  1  head entry valid.
- `op_1_out`, `op_2_out`  out  32 each  ALU operands.
- `opcode_out`  out  4  ALU opcode.
- `rd_addr_out`  out  5  head entry destination register.

## Operation
- Storage is two entries, head (drives outputs) and skid. Each entry holds:
  - op1, op2, opcode, rd;
  - src1 flag + rs1 index (op1 came from rs1);
  - src2 flag + rs2 index (op2 came from rs2).
- Opcode encoding:
  - If `op1_sel_in != 00`, opcode is 0000 (LUI/AUIPC add).
  - Otherwise opcode is {b3, `funct3_in`}.
  - b3 = `funct7_5_in` when funct3 = 101.
  - b3 = `funct7_5_in && !imm_sel_in` when funct3 = 000.
  - b3 = 0 in all other cases.
  - Results: ADD 0000, SUB 1000, SLT 0010, SLTU 0011, XOR 0100, OR 0110, AND 0111, SLL 0001, SRL 0101, SRA 1101.
- Bypass at capture: a source operand takes `wb_data_in` when `wb_en_in`, `wb_addr_in == index`, and `wb_addr_in != 0`. Otherwise it takes the regfile value. x0 is never bypassed.
- Snoop while held: each cycle, a valid entry with the src flag set and a matching nonzero `wb_addr_in` under `wb_en_in` replaces that operand with `wb_data_in`.
- Buffer control:
  - Accept into head when head is empty or being consumed (`valid_out && ready_in`); otherwise accept into skid.
  - On consume with skid valid, skid moves to head; snoop applies to the moved entry in the same cycle.
  - `ready_out` = !skid_valid, registered.
- Flush: `flush_in` has highest priority. Both entries are invalidated next cycle, and the same-cycle `valid_in` is not accepted. A consume in the flush cycle still counts downstream.

## Timing
- Reset values:
  - `valid_out` = 0, `ready_out` = 1.
  - `op_1_out`, `op_2_out` = 0.
  - `opcode_out`, `rd_addr_out` = 0.
  - Both entry valid bits = 0.
- Latency: an instruction accepted at edge N is presented with `valid_out` = 1 after edge N.
- Throughput: one instruction per cycle while `ready_in` = 1.
- Back-pressure: `ready_in` = 0 with head full absorbs exactly one more instruction into skid; `ready_out` then drops after that edge.
- Outputs are stable while `valid_out && !ready_in`, except snoop updates of operands.
- Reset mid-operation: both entries are dropped; no instruction is emitted after reset.
- Simultaneous accept + consume + writeback hit: the captured and moved entries both see the bypass.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: capture bypass and held-entry snoop are compiled in.
- `ALU_ISSUE_FWD_EN` undefined:
  - Operands come only from `rs1_data_in`/`rs2_data_in`.
  - Src flags/indices are not stored.
  - `wb_*_in` ports remain but are ignored.

## Test plan
- ADD: rs1=5, rs2=7, funct3=000, funct7_5=0, `ready_in`=1 → next cycle `opcode_out`=0000, ops 5/7, `valid_out`=1.
- Shifts and ADDI:
  - SRAI: imm=3, funct7_5=1, funct3=101 → opcode 1101, `op_2_out`=3.
  - ADDI with funct7_5=1 → opcode 0000.
- Back-pressure: issue A, B, C back-to-back with `ready_in`=0 → A in head, B in skid, `ready_out`=0, C held upstream. Then raise `ready_in` → A, B, C emitted in order, one per cycle.
- Bypass at capture (FWD_EN): rs1=x3 (regfile 0x10), `wb_en_in`=1, wb x3=0x99 same cycle → `op_1_out`=0x99. With wb to x0 → no bypass.
- Held snoop (FWD_EN): entry stalled, wb x4=0xAB while entry src2=x4 → `op_2_out` becomes 0xAB next cycle. If op2 came from imm → unchanged.
- Flush and reset:
  - `flush_in`=1 with both entries full and `valid_in`=1 → next cycle `valid_out`=0, `ready_out`=1.
  - `rst_n_in`=0 mid-stall → all outputs 0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ALU issue stage: operand select, bypass, opcode encode, 2-entry skid buffer.
// Optional writeback forwarding enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue_stage (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [31:0] rs1_data_in,
    input  logic [31:0] rs2_data_in,
    input  logic [31:0] imm_in,
    input  logic [31:0] pc_in,
    input  logic [4:0]  rs1_addr_in,
    input  logic [4:0]  rs2_addr_in,
    input  logic [4:0]  rd_addr_in,
    input  logic [2:0]  funct3_in,
    input  logic        funct7_5_in,
    input  logic        imm_sel_in,
    input  logic [1:0]  op1_sel_in,
    input  logic        wb_en_in,
    input  logic [4:0]  wb_addr_in,
    input  logic [31:0] wb_data_in,
    input  logic        flush_in,
    input  logic        ready_in,
    output logic        valid_out,
    output logic [31:0] op_1_out,
    output logic [31:0] op_2_out,
    output logic [3:0]  opcode_out,
    output logic [4:0]  rd_addr_out
);

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  opcode;
        logic [4:0]  rd;
`ifdef ALU_ISSUE_FWD_EN
        logic        s1;
        logic [4:0]  a1;
        logic        s2;
        logic [4:0]  a2;
`endif
    } entry_t;

    entry_t      head_q;
    entry_t      skid_q;
    entry_t      head_s;
    entry_t      skid_s;
    entry_t      cap;
    logic        head_v_q;
    logic        skid_v_q;
    logic        ready_q;
    logic        consume;
    logic        accept;
    logic        b3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

`ifdef ALU_ISSUE_FWD_EN
    function automatic logic hit(
        input logic       en,
        input logic [4:0] wa,
        input logic [4:0] a
    );
        return en && (wa == a) && (wa != 5'd0);
    endfunction

    function automatic entry_t snoop(
        input entry_t      e,
        input logic        en,
        input logic [4:0]  wa,
        input logic [31:0] wd
    );
        entry_t r;
        r = e;
        if (e.s1 && hit(en, wa, e.a1)) r.op1 = wd;
        if (e.s2 && hit(en, wa, e.a2)) r.op2 = wd;
        return r;
    endfunction
`else
    logic unused_fwd;
    assign unused_fwd = ^{wb_en_in, wb_addr_in, wb_data_in,
                          rs1_addr_in, rs2_addr_in};

    function automatic entry_t snoop(
        input entry_t      e,
        input logic        en,
        input logic [4:0]  wa,
        input logic [31:0] wd
    );
        return e;
    endfunction
`endif

    always_comb begin
        rs1_val = rs1_data_in;
        rs2_val = rs2_data_in;
`ifdef ALU_ISSUE_FWD_EN
        if (hit(wb_en_in, wb_addr_in, rs1_addr_in)) rs1_val = wb_data_in;
        if (hit(wb_en_in, wb_addr_in, rs2_addr_in)) rs2_val = wb_data_in;
`endif
    end

    // Only SUB (R-type funct3 000) and SRA/SRAI (funct3 101) set bit 3.
    always_comb begin
        b3 = 1'b0;
        unique case (funct3_in)
            3'b101:  b3 = funct7_5_in;
            3'b000:  b3 = funct7_5_in && !imm_sel_in;
            default: b3 = 1'b0;
        endcase
    end

    always_comb begin
        cap = '0;
        unique case (op1_sel_in)
            2'b00:   cap.op1 = rs1_val;
            2'b01:   cap.op1 = pc_in;
            default: cap.op1 = 32'd0;
        endcase
        cap.op2    = imm_sel_in ? imm_in : rs2_val;
        cap.opcode = (op1_sel_in != 2'b00) ? 4'b0000 : {b3, funct3_in};
        cap.rd     = rd_addr_in;
`ifdef ALU_ISSUE_FWD_EN
        cap.s1 = (op1_sel_in == 2'b00);
        cap.a1 = rs1_addr_in;
        cap.s2 = !imm_sel_in;
        cap.a2 = rs2_addr_in;
`endif
    end

    assign head_s  = snoop(head_q, wb_en_in, wb_addr_in, wb_data_in);
    assign skid_s  = snoop(skid_q, wb_en_in, wb_addr_in, wb_data_in);
    assign consume = head_v_q && ready_in;
    assign accept  = valid_in && ready_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            head_q   <= '0;
            skid_q   <= '0;
            head_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            ready_q  <= 1'b1;
        end else if (flush_in) begin
            head_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            ready_q  <= 1'b1;
        end else if (!head_v_q || consume) begin
            if (skid_v_q) begin
                head_q   <= skid_s;
                head_v_q <= 1'b1;
                skid_v_q <= 1'b0;
                ready_q  <= 1'b1;
            end else begin
                head_q   <= accept ? cap : head_s;
                head_v_q <= accept;
            end
        end else begin
            head_q <= head_s;
            if (accept) begin
                skid_q   <= cap;
                skid_v_q <= 1'b1;
                ready_q  <= 1'b0;
            end else begin
                skid_q <= skid_s;
            end
        end
    end

    assign ready_out   = ready_q;
    assign valid_out   = head_v_q;
    assign op_1_out    = head_q.op1;
    assign op_2_out    = head_q.op2;
    assign opcode_out  = head_q.opcode;
    assign rd_addr_out = head_q.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage against a queue-based model.
// Forwarding scenarios are exercised when ALU_ISSUE_FWD_EN is defined.
module tb_alu_issue_stage;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] rs1_data_in;
    logic [31:0] rs2_data_in;
    logic [31:0] imm_in;
    logic [31:0] pc_in;
    logic [4:0]  rs1_addr_in;
    logic [4:0]  rs2_addr_in;
    logic [4:0]  rd_addr_in;
    logic [2:0]  funct3_in;
    logic        funct7_5_in;
    logic        imm_sel_in;
    logic [1:0]  op1_sel_in;
    logic        wb_en_in;
    logic [4:0]  wb_addr_in;
    logic [31:0] wb_data_in;
    logic        flush_in;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] op_1_out;
    logic [31:0] op_2_out;
    logic [3:0]  opcode_out;
    logic [4:0]  rd_addr_out;

    int checks = 0;
    int failures = 0;

`ifdef ALU_ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  opc;
        logic [4:0]  rd;
        bit          from_rs1;
        logic [4:0]  a1;
        bit          from_rs2;
        logic [4:0]  a2;
    } ent_t;

    ent_t q[$];

    alu_issue_stage dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .rs1_data_in (rs1_data_in),
        .rs2_data_in (rs2_data_in),
        .imm_in      (imm_in),
        .pc_in       (pc_in),
        .rs1_addr_in (rs1_addr_in),
        .rs2_addr_in (rs2_addr_in),
        .rd_addr_in  (rd_addr_in),
        .funct3_in   (funct3_in),
        .funct7_5_in (funct7_5_in),
        .imm_sel_in  (imm_sel_in),
        .op1_sel_in  (op1_sel_in),
        .wb_en_in    (wb_en_in),
        .wb_addr_in  (wb_addr_in),
        .wb_data_in  (wb_data_in),
        .flush_in    (flush_in),
        .ready_in    (ready_in),
        .valid_out   (valid_out),
        .op_1_out    (op_1_out),
        .op_2_out    (op_2_out),
        .opcode_out  (opcode_out),
        .rd_addr_out (rd_addr_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit wb_hits(input logic [4:0] a);
        return FWD && wb_en_in && a != 0 && wb_addr_in == a;
    endfunction

    function automatic logic [3:0] ref_opcode();
        if (op1_sel_in != 2'b00) return 4'b0000;
        if (funct3_in == 3'b101) return {funct7_5_in, 3'b101};
        if (funct3_in == 3'b000 && funct7_5_in && !imm_sel_in)
            return 4'b1000;
        return {1'b0, funct3_in};
    endfunction

    function automatic ent_t ref_capture();
        ent_t e;
        e.from_rs1 = (op1_sel_in == 2'b00);
        e.a1 = rs1_addr_in;
        e.from_rs2 = !imm_sel_in;
        e.a2 = rs2_addr_in;
        if (op1_sel_in == 2'b01) e.op1 = pc_in;
        else if (op1_sel_in != 2'b00) e.op1 = 0;
        else e.op1 = wb_hits(rs1_addr_in) ? wb_data_in : rs1_data_in;
        if (imm_sel_in) e.op2 = imm_in;
        else e.op2 = wb_hits(rs2_addr_in) ? wb_data_in : rs2_data_in;
        e.opc = ref_opcode();
        e.rd = rd_addr_in;
        return e;
    endfunction

    function automatic ent_t ref_snoop(input ent_t e);
        ent_t r = e;
        if (e.from_rs1 && wb_hits(e.a1)) r.op1 = wb_data_in;
        if (e.from_rs2 && wb_hits(e.a2)) r.op2 = wb_data_in;
        return r;
    endfunction

    task automatic check_state();
        chk("valid_out", valid_out, q.size() > 0);
        chk("ready_out", ready_out, q.size() < 2);
        if (q.size() > 0) begin
            chk("op_1_out", op_1_out, q[0].op1);
            chk("op_2_out", op_2_out, q[0].op2);
            chk("opcode_out", opcode_out, q[0].opc);
            chk("rd_addr_out", rd_addr_out, q[0].rd);
        end
    endtask

    task automatic step();
        ent_t nq[$];
        bit   room;
        nq = q;
        room = q.size() < 2;
        if (!rst_n_in || flush_in) begin
            nq = {};
        end else begin
            if (nq.size() > 0 && ready_in) void'(nq.pop_front());
            foreach (nq[i]) nq[i] = ref_snoop(nq[i]);
            if (valid_in && room) nq.push_back(ref_capture());
        end
        @(posedge clk_in);
        #1;
        q = nq;
        check_state();
    endtask

    task automatic instr(input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] im, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] rd,
                         input logic [2:0] f3, input logic f7,
                         input logic isel, input logic [1:0] o1);
        valid_in    = 1'b1;
        rs1_data_in = r1;
        rs2_data_in = r2;
        imm_in      = im;
        pc_in       = 32'h1000;
        rs1_addr_in = a1;
        rs2_addr_in = a2;
        rd_addr_in  = rd;
        funct3_in   = f3;
        funct7_5_in = f7;
        imm_sel_in  = isel;
        op1_sel_in  = o1;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        flush_in = 1'b0;
        wb_en_in = 1'b0;
        ready_in = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        rst_n_in = 1'b0;
        flush_in = 1'b0;
        ready_in = 1'b1;
        wb_en_in = 1'b0;
        wb_addr_in = 0;
        wb_data_in = 0;
        instr(0, 0, 0, 0, 0, 0, 3'b000, 1'b0, 1'b0, 2'b00);
        valid_in = 1'b0;
        step();
        step();
        chk("rst_op1", op_1_out, 0);
        chk("rst_op2", op_2_out, 0);
        chk("rst_opcode", opcode_out, 0);
        chk("rst_rd", rd_addr_out, 0);
        rst_n_in = 1'b1;
        idle(1);

        instr(5, 7, 0, 1, 2, 3, 3'b000, 1'b0, 1'b0, 2'b00);
        step();
        chk("add_opcode", opcode_out, 4'b0000);
        chk("add_op1", op_1_out, 5);
        chk("add_op2", op_2_out, 7);
        chk("add_valid", valid_out, 1);

        instr(9, 0, 3, 1, 2, 4, 3'b101, 1'b1, 1'b1, 2'b00);
        step();
        chk("srai_opcode", opcode_out, 4'b1101);
        chk("srai_op2", op_2_out, 3);
        instr(9, 0, 3, 1, 2, 4, 3'b000, 1'b1, 1'b1, 2'b00);
        step();
        chk("addi_opcode", opcode_out, 4'b0000);
        instr(9, 4, 0, 1, 2, 4, 3'b000, 1'b1, 1'b0, 2'b00);
        step();
        chk("sub_opcode", opcode_out, 4'b1000);
        instr(9, 4, 32'h12345000, 1, 2, 4, 3'b111, 1'b1, 1'b1, 2'b01);
        step();
        chk("auipc_opcode", opcode_out, 4'b0000);
        chk("auipc_op1", op_1_out, 32'h1000);
        idle(2);

        ready_in = 1'b0;
        instr(1, 1, 0, 1, 2, 5'd1, 3'b100, 1'b0, 1'b0, 2'b00);
        step();
        instr(2, 2, 0, 1, 2, 5'd2, 3'b110, 1'b0, 1'b0, 2'b00);
        step();
        chk("bp_ready_low", ready_out, 0);
        instr(3, 3, 0, 1, 2, 5'd3, 3'b111, 1'b0, 1'b0, 2'b00);
        step();
        step();
        chk("bp_head_a", rd_addr_out, 1);
        ready_in = 1'b1;
        step();
        chk("bp_emit_b", rd_addr_out, 2);
        step();
        chk("bp_emit_c", rd_addr_out, 3);
        valid_in = 1'b0;
        step();
        chk("bp_drained", valid_out, 0);

`ifdef ALU_ISSUE_FWD_EN
        wb_en_in = 1'b1;
        wb_addr_in = 5'd3;
        wb_data_in = 32'h99;
        instr(32'h10, 0, 0, 5'd3, 5'd9, 5'd5, 3'b000, 1'b0, 1'b0, 2'b00);
        step();
        chk("byp_op1", op_1_out, 32'h99);
        wb_addr_in = 5'd0;
        instr(32'h10, 0, 0, 5'd0, 5'd9, 5'd5, 3'b000, 1'b0, 1'b0, 2'b00);
        step();
        chk("byp_x0", op_1_out, 32'h10);
        idle(1);
        ready_in = 1'b0;
        instr(1, 32'h22, 0, 5'd7, 5'd4, 5'd6, 3'b000, 1'b0, 1'b0, 2'b00);
        step();
        valid_in = 1'b0;
        wb_en_in = 1'b1;
        wb_addr_in = 5'd4;
        wb_data_in = 32'hAB;
        step();
        chk("snoop_op2", op_2_out, 32'hAB);
        idle(1);
        ready_in = 1'b0;
        instr(1, 32'h22, 32'h55, 5'd7, 5'd4, 5'd6, 3'b000, 1'b0, 1'b1,
              2'b00);
        step();
        valid_in = 1'b0;
        wb_en_in = 1'b1;
        wb_addr_in = 5'd4;
        wb_data_in = 32'hCD;
        step();
        chk("snoop_imm", op_2_out, 32'h55);
`else
        wb_en_in = 1'b1;
        wb_addr_in = 5'd3;
        wb_data_in = 32'h99;
        instr(32'h10, 0, 0, 5'd3, 5'd9, 5'd5, 3'b000, 1'b0, 1'b0, 2'b00);
        step();
        chk("nofwd_op1", op_1_out, 32'h10);
`endif
        idle(2);

        ready_in = 1'b0;
        instr(1, 1, 0, 1, 2, 5'd8, 3'b000, 1'b0, 1'b0, 2'b00);
        step();
        step();
        flush_in = 1'b1;
        step();
        chk("flush_valid", valid_out, 0);
        chk("flush_ready", ready_out, 1);
        flush_in = 1'b0;
        valid_in = 1'b0;
        step();

        instr(4, 4, 0, 1, 2, 5'd9, 3'b000, 1'b0, 1'b0, 2'b00);
        step();
        step();
        rst_n_in = 1'b0;
        step();
        chk("mid_rst_valid", valid_out, 0);
        chk("mid_rst_op1", op_1_out, 0);
        chk("mid_rst_op2", op_2_out, 0);
        chk("mid_rst_opc", opcode_out, 0);
        chk("mid_rst_rd", rd_addr_out, 0);
        rst_n_in = 1'b1;
        valid_in = 1'b0;
        step();
        chk("post_rst_valid", valid_out, 0);

        for (int i = 0; i < 3000; i++) begin
            instr($urandom, $urandom, $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom), 3'($urandom), 1'($urandom),
                  1'($urandom), 2'($urandom));
            pc_in      = $urandom;
            valid_in   = ($urandom_range(0, 3) != 0);
            ready_in   = ($urandom_range(0, 9) < 6);
            wb_en_in   = 1'($urandom);
            wb_addr_in = 5'($urandom_range(0, 7));
            wb_data_in = $urandom;
            flush_in   = ($urandom_range(0, 39) == 0);
            rst_n_in   = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
